alu_seq_mult: RTL and testbench

//  Iterative unsigned shift-add multiplier that drives an external ALU for its additions.
//  It sits directly upstream of the ALU:
//    - owns the ALU operand and control lines during a multiply;
//    - consumes aluOut and cOut;
//    - builds a 2*WIDTH-bit product over WIDTH cycles.

---
 rtl/alu_seq_mult_pkg.sv | 17 +
 rtl/alu_seq_mult_if.sv | 31 +++
 rtl/alu_seq_mult.sv | 98 +++++++++
 tb/tb_alu_seq_mult.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_mult_pkg.sv
// Shared ALU control encodings and multiplier state type.
package alu_seq_mult_pkg;

    localparam logic [2:0] ALU_PASS_B   = 3'b000;
    localparam logic [2:0] ALU_ADD      = 3'b010;
    localparam logic [2:0] ALU_SUBTRACT = 3'b011;
    localparam logic [2:0] ALU_AND      = 3'b100;
    localparam logic [2:0] ALU_OR       = 3'b101;
    localparam logic [2:0] ALU_XOR      = 3'b110;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu_seq_mult_if.sv
// Execute-stage handshake to the sequential multiplier (start/busy/done + operands/result).
interface alu_seq_mult_if #(
    parameter int unsigned WIDTH = 64
);

    logic                   start;
    logic [WIDTH-1:0]       mcand;
    logic [WIDTH-1:0]       mplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start,
        output mcand,
        output mplier,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  mcand,
        input  mplier,
        output busy,
        output done,
        output product
    );

endinterface

// File: rtl/alu_seq_mult.sv
// Iterative unsigned shift-add multiplier using an external ALU for each partial-sum add.
module alu_seq_mult
    import alu_seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    alu_seq_mult_if.slave       mul,
    output logic [WIDTH-1:0]    aluA,
    output logic [WIDTH-1:0]    aluB,
    output logic [2:0]          aluCtrl,
    output logic                aluCIn,
    input  logic [WIDTH-1:0]    aluResult,
    input  logic                aluCOut
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    mul_state_t             state,    state_nxt;
    logic [WIDTH-1:0]       acc_hi,   acc_hi_nxt;
    logic [WIDTH-1:0]       mplier_q, mplier_nxt;
    logic [WIDTH-1:0]       mcand_q,  mcand_nxt;
    logic [CNT_W-1:0]       cnt,      cnt_nxt;
    logic [2*WIDTH-1:0]     product,  product_nxt;
    logic                   busy_q;
    logic                   done_q;
    logic [WIDTH-1:0]       alu_b_q;

    // Next-state and datapath: capture on start, one shift-add step per RUN cycle.
    always_comb begin
        state_nxt   = state;
        acc_hi_nxt  = acc_hi;
        mplier_nxt  = mplier_q;
        mcand_nxt   = mcand_q;
        cnt_nxt     = cnt;
        product_nxt = product;
        case (state)
            MUL_IDLE, MUL_DONE: begin
                if (mul.start) begin
                    state_nxt  = MUL_RUN;
                    mcand_nxt  = mul.mcand;
                    mplier_nxt = mul.mplier;
                    acc_hi_nxt = '0;
                    cnt_nxt    = CNT_W'(WIDTH);
                end else begin
                    state_nxt  = MUL_IDLE;
                end
            end
            MUL_RUN: begin
                // carry lands in the acc top bit; sum LSB shifts into the multiplier/acc_lo
                {acc_hi_nxt, mplier_nxt} = {aluCOut, aluResult, mplier_q[WIDTH-1:1]};
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt   = MUL_DONE;
                    product_nxt = {acc_hi_nxt, mplier_nxt};
                end
            end
            default: begin
                state_nxt = MUL_IDLE;
            end
        endcase
    end

    // State and datapath registers; flags and ALU operand B registered from next values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= MUL_IDLE;
            acc_hi   <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            cnt      <= '0;
            product  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            alu_b_q  <= '0;
        end else begin
            state    <= state_nxt;
            acc_hi   <= acc_hi_nxt;
            mplier_q <= mplier_nxt;
            mcand_q  <= mcand_nxt;
            cnt      <= cnt_nxt;
            product  <= product_nxt;
            busy_q   <= (state_nxt == MUL_RUN);
            done_q   <= (state_nxt == MUL_DONE);
            alu_b_q  <= mplier_nxt[0] ? mcand_nxt : '0;
        end
    end

    assign mul.busy    = busy_q;
    assign mul.done    = done_q;
    assign mul.product = product;
    assign aluA        = acc_hi;
    assign aluB        = alu_b_q;
    assign aluCtrl     = ALU_ADD;
    assign aluCIn      = 1'b0;

endmodule

// File: tb/tb_alu_seq_mult.sv
// Scoreboard bench for alu_seq_mult (WIDTH=4) wired to a behavioural 4-bit ALU.
module tb_alu_seq_mult;
    import alu_seq_mult_pkg::*;

    localparam int unsigned W = 4;

    logic           clk;
    logic           reset_n;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [2:0]     alu_ctrl;
    logic           alu_cin;
    logic [W-1:0]   alu_result;
    logic           alu_cout;

    alu_seq_mult_if #(.WIDTH(W)) mul ();

    alu_seq_mult #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mul       (mul.slave),
        .aluA      (alu_a),
        .aluB      (alu_b),
        .aluCtrl   (alu_ctrl),
        .aluCIn    (alu_cin),
        .aluResult (alu_result),
        .aluCOut   (alu_cout)
    );

    // 4-bit ALU slice beside the multiplier
    always_comb begin
        logic [W:0] s;
        s = '0;
        case (alu_ctrl)
            ALU_PASS_B:   s = {1'b0, alu_b};
            ALU_ADD:      s = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
            ALU_SUBTRACT: s = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
            ALU_AND:      s = {1'b0, alu_a & alu_b};
            ALU_OR:       s = {1'b0, alu_a | alu_b};
            ALU_XOR:      s = {1'b0, alu_a ^ alu_b};
            default:      s = '0;
        endcase
        {alu_cout, alu_result} = s;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [2*W-1:0] sb_q [$];
    int run_cnt = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: on every done pulse pop the expected product and check RUN length.
    always @(negedge clk) begin
        if (!reset_n) begin
            run_cnt = 0;
        end else begin
            if (mul.busy) run_cnt++;
            if (mul.done) begin
                chk("done_not_busy", longint'(mul.busy), 0);
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    chk("product", longint'(mul.product), longint'(sb_q.pop_front()));
                end
                chk("run_cycles", run_cnt, W);
                run_cnt = 0;
            end
        end
    end

    task automatic wait_done();
        int g = 0;
        while (!mul.done && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        if (!mul.done) chk("done_timeout", 0, 1);
    endtask

    // Issue one op from IDLE/DONE, wait for its done, then idle for gap cycles.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int gap);
        mul.start  = 1'b1;
        mul.mcand  = a;
        mul.mplier = b;
        sb_q.push_back(8'({4'b0, a} * {4'b0, b}));
        @(posedge clk); #1;
        mul.start  = 1'b0;
        mul.mcand  = 4'($urandom);
        mul.mplier = 4'($urandom);
        chk("busy_after_start", longint'(mul.busy), 1);
        wait_done();
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a2, b2;
        int g;
        reset_n    = 1'b0;
        mul.start  = 1'b0;
        mul.mcand  = '0;
        mul.mplier = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",    longint'(mul.busy),    0);
        chk("rst_done",    longint'(mul.done),    0);
        chk("rst_product", longint'(mul.product), 0);
        chk("rst_alu_a",   longint'(alu_a),       0);
        chk("rst_alu_b",   longint'(alu_b),       0);
        chk("alu_ctrl",    longint'(alu_ctrl),    longint'(ALU_ADD));
        chk("alu_cin",     longint'(alu_cin),     0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", longint'(mul.busy), 0);

        // directed cases
        run_op(4'd3,  4'd5,  1);
        run_op(4'hF,  4'hF,  0);
        run_op(4'd0,  4'hA,  1);
        run_op(4'd9,  4'd0,  2);

        // start held through RUN with changing operands, then back-to-back launch from DONE
        mul.start  = 1'b1;
        mul.mcand  = 4'd2;
        mul.mplier = 4'd6;
        sb_q.push_back(8'h0C);
        @(posedge clk); #1;
        g = 0;
        while (mul.busy && g < 20) begin
            mul.mcand  = 4'($urandom);
            mul.mplier = 4'($urandom);
            @(posedge clk); #1;
            g++;
        end
        chk("held_done", longint'(mul.done), 1);
        a2 = 4'($urandom);
        b2 = 4'($urandom);
        mul.mcand  = a2;
        mul.mplier = b2;
        sb_q.push_back(8'({4'b0, a2} * {4'b0, b2}));
        @(posedge clk); #1;
        mul.start = 1'b0;
        chk("b2b_busy", longint'(mul.busy), 1);
        wait_done();
        @(posedge clk); #1;

        // reset in the second RUN cycle of 7*7
        mul.start  = 1'b1;
        mul.mcand  = 4'd7;
        mul.mplier = 4'd7;
        sb_q.push_back(8'h31);
        @(posedge clk); #1;
        mul.start = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_busy", longint'(mul.busy), 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy",    longint'(mul.busy),    0);
        chk("midrst_done",    longint'(mul.done),    0);
        chk("midrst_product", longint'(mul.product), 0);
        sb_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_op(4'd7, 4'd7, 1);

        // exhaustive sweep with random idle gaps
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(4'(a), 4'(b), int'($urandom_range(0, 2)));
            end
        end

        // random operands
        for (int i = 0; i < 40; i++) begin
            run_op(4'($urandom), 4'($urandom), int'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", longint'(sb_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
